// File: rtl/npu_ctrl_pkg.sv
// Shared types for the NPU control path: layer descriptor layout and dispatcher states.
package npu_ctrl_pkg;

    localparam int FRAM_AW = 16;
    localparam int KRAM_AW = 16;
    localparam int DATA_W  = 16;

    typedef struct packed {
        logic [FRAM_AW-1:0] feature_baseaddr;
        logic [KRAM_AW-1:0] kernel_baseaddr;
        logic [FRAM_AW-1:0] wb_baseaddr;
        logic [DATA_W-1:0]  chin;
        logic [DATA_W-1:0]  chout;
        logic [DATA_W-1:0]  width;
        logic [DATA_W-1:0]  height;
        logic [DATA_W-1:0]  ksh;
        logic [DATA_W-1:0]  ksw;
        logic               has_bias;
        logic               has_relu;
    } layer_desc_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_ERROR
    } disp_state_e;

endpackage

// File: rtl/desc_fifo.sv
// Synchronous descriptor FIFO with synchronous clear; push while full is accepted only alongside a pop.
module desc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && (!full || do_pop) && !clear;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/layer_dispatcher.sv
// Queues host layer descriptors and issues them one at a time to the decoder,
// tracking completion, layer count, done pulse and a per-layer watchdog.
module layer_dispatcher
    import npu_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16,
    parameter int TMO_CYCLES = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               abort,
    input  logic               desc_valid,
    output logic               desc_ready,
    input  layer_desc_t        desc,
    output logic               inst_valid,
    input  logic               decoder_ready,
    output logic [FRAM_AW-1:0] feature_baseaddr,
    output logic [KRAM_AW-1:0] kernel_baseaddr,
    output logic [DATA_W-1:0]  feature_chin,
    output logic [DATA_W-1:0]  feature_chout,
    output logic [DATA_W-1:0]  feature_width,
    output logic [DATA_W-1:0]  feature_height,
    output logic [DATA_W-1:0]  kernel_sizeh,
    output logic [DATA_W-1:0]  kernel_sizew,
    output logic               has_bias,
    output logic               has_relu,
    output logic [FRAM_AW-1:0] wb_baseaddr,
    input  logic               wb_busy,
    output logic               busy,
    output logic [CNT_W-1:0]   layers_done,
    output logic               done_pulse,
    output logic               err_timeout
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [31:0] TMO_LIM = 32'(TMO_CYCLES);

    disp_state_e  state;
    layer_desc_t  head, cur;
    logic         fifo_full, fifo_empty;
    logic [AW:0]  fifo_count;
    logic         rdy_en, abort_pend;
    logic [31:0]  wdog;
    logic         in_wait, can_issue, accept, layer_fin, tmo_hit, pop, push;

    assign in_wait   = (state == ST_WAIT_BUSY) || (state == ST_WAIT_DONE);
    assign can_issue = enable && !fifo_empty && !abort;
    assign accept    = (state == ST_ISSUE) && inst_valid && decoder_ready;
    assign layer_fin = (state == ST_WAIT_DONE) && decoder_ready && !wb_busy;
    assign tmo_hit   = (TMO_LIM != 32'd0) && in_wait && (wdog >= TMO_LIM - 32'd1);
    // An aborted layer still completes but must not chain into a new issue.
    assign pop       = can_issue && ((state == ST_IDLE) || (layer_fin && !abort_pend));
    assign desc_ready = rdy_en && (!fifo_full || pop);
    assign push      = desc_valid && desc_ready && !abort;
    assign busy      = (state != ST_IDLE) || (fifo_count != '0);

    desc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(layer_desc_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (abort),
        .push  (push),
        .pop   (pop),
        .wdata (desc),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            inst_valid  <= 1'b0;
            cur         <= '0;
            layers_done <= '0;
            done_pulse  <= 1'b0;
            err_timeout <= 1'b0;
            wdog        <= '0;
            rdy_en      <= 1'b0;
            abort_pend  <= 1'b0;
        end else begin
            rdy_en     <= 1'b1;
            done_pulse <= 1'b0;
            if (pop) cur <= head;
            if (accept)                       wdog <= '0;
            else if (in_wait && wdog != '1)   wdog <= wdog + 32'd1;

            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        inst_valid <= 1'b1;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // A completed handshake wins over a same-cycle abort: the decoder already has it.
                    if (accept) begin
                        inst_valid <= 1'b0;
                        abort_pend <= abort;
                        state      <= ST_WAIT_BUSY;
                    end else if (abort) begin
                        inst_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (abort) abort_pend <= 1'b1;
                    if (tmo_hit) begin
                        err_timeout <= 1'b1;
                        state       <= ST_ERROR;
                    end else if (!decoder_ready) begin
                        state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (layer_fin) begin
                        layers_done <= layers_done + 1'b1;
                        done_pulse  <= fifo_empty && !abort_pend && !abort;
                        abort_pend  <= 1'b0;
                        if (pop) begin
                            inst_valid <= 1'b1;
                            state      <= ST_ISSUE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        if (abort) abort_pend <= 1'b1;
                        if (tmo_hit) begin
                            err_timeout <= 1'b1;
                            state       <= ST_ERROR;
                        end
                    end
                end
                ST_ERROR: begin
                    if (abort) begin
                        err_timeout <= 1'b0;
                        abort_pend  <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign feature_baseaddr = cur.feature_baseaddr;
    assign kernel_baseaddr  = cur.kernel_baseaddr;
    assign wb_baseaddr      = cur.wb_baseaddr;
    assign feature_chin     = cur.chin;
    assign feature_chout    = cur.chout;
    assign feature_width    = cur.width;
    assign feature_height   = cur.height;
    assign kernel_sizeh     = cur.ksh;
    assign kernel_sizew     = cur.ksw;
    assign has_bias         = cur.has_bias;
    assign has_relu         = cur.has_relu;

endmodule

// File: tb/tb_layer_dispatcher.sv
// Bench for layer_dispatcher: cycle table, directed corner sequences, and a randomized
// run scored against a transaction-level queue model with a simple decoder responder.
`timescale 1ns/1ps
module tb_layer_dispatcher;
    import npu_ctrl_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0, abort = 1'b0, desc_valid = 1'b0, decoder_ready = 1'b0, wb_busy = 1'b0;
    layer_desc_t desc = '0;

    logic               desc_ready, inst_valid, has_bias, has_relu, busy, done_pulse, err_timeout;
    logic [FRAM_AW-1:0] feature_baseaddr, wb_baseaddr;
    logic [KRAM_AW-1:0] kernel_baseaddr;
    logic [DATA_W-1:0]  feature_chin, feature_chout, feature_width, feature_height;
    logic [DATA_W-1:0]  kernel_sizeh, kernel_sizew;
    logic [15:0]        layers_done;
    layer_desc_t        out_d;

    always #5 clk = ~clk;

    layer_dispatcher #(.FIFO_DEPTH(DEPTH), .CNT_W(16), .TMO_CYCLES(100)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .abort(abort),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc(desc),
        .inst_valid(inst_valid), .decoder_ready(decoder_ready),
        .feature_baseaddr(feature_baseaddr), .kernel_baseaddr(kernel_baseaddr),
        .feature_chin(feature_chin), .feature_chout(feature_chout),
        .feature_width(feature_width), .feature_height(feature_height),
        .kernel_sizeh(kernel_sizeh), .kernel_sizew(kernel_sizew),
        .has_bias(has_bias), .has_relu(has_relu), .wb_baseaddr(wb_baseaddr),
        .wb_busy(wb_busy), .busy(busy), .layers_done(layers_done),
        .done_pulse(done_pulse), .err_timeout(err_timeout)
    );

    always_comb begin
        out_d.feature_baseaddr = feature_baseaddr;
        out_d.kernel_baseaddr  = kernel_baseaddr;
        out_d.wb_baseaddr      = wb_baseaddr;
        out_d.chin             = feature_chin;
        out_d.chout            = feature_chout;
        out_d.width            = feature_width;
        out_d.height           = feature_height;
        out_d.ksh              = kernel_sizeh;
        out_d.ksw              = kernel_sizew;
        out_d.has_bias         = has_bias;
        out_d.has_relu         = has_relu;
    end

    int errs = 0, checks = 0;

    task automatic chk1(input string nm, input logic a, input logic e);
        checks++;
        if (a !== e) begin errs++; $display("FAIL %s: got %b want %b", nm, a, e); end
    endtask

    task automatic chkn(input string nm, input int a, input int e);
        checks++;
        if (a != e) begin errs++; $display("FAIL %s: got %0d want %0d", nm, a, e); end
    endtask

    task automatic chkd(input string nm, input layer_desc_t a, input layer_desc_t e);
        checks++;
        if (a !== e) begin errs++; $display("FAIL %s: got %h want %h", nm, a, e); end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic layer_desc_t mk_desc(input int tag);
        layer_desc_t d;
        d.feature_baseaddr = FRAM_AW'(32'h1000 + tag);
        d.kernel_baseaddr  = KRAM_AW'(32'h2000 + tag);
        d.wb_baseaddr      = FRAM_AW'(32'h3000 + tag);
        d.chin             = DATA_W'(tag);
        d.chout            = DATA_W'(tag * 2);
        d.width            = DATA_W'(100 + tag);
        d.height           = DATA_W'(50 + tag);
        d.ksh              = DATA_W'(3);
        d.ksw              = DATA_W'(3);
        d.has_bias         = tag[0];
        d.has_relu         = ~tag[0];
        return d;
    endfunction

    function automatic layer_desc_t rnd_desc();
        layer_desc_t d;
        d.feature_baseaddr = FRAM_AW'($urandom);
        d.kernel_baseaddr  = KRAM_AW'($urandom);
        d.wb_baseaddr      = FRAM_AW'($urandom);
        d.chin             = DATA_W'($urandom);
        d.chout            = DATA_W'($urandom);
        d.width            = DATA_W'($urandom);
        d.height           = DATA_W'($urandom);
        d.ksh              = DATA_W'($urandom);
        d.ksw              = DATA_W'($urandom);
        d.has_bias         = 1'($urandom);
        d.has_relu         = 1'($urandom);
        return d;
    endfunction

    typedef struct {
        logic dv, en, dr, wb;
        int   tag;
        logic rdy, iv, bsy, dp;
        int   ld;
        int   exp_tag;
    } vec_t;

    function automatic vec_t v(input logic dv, input logic en, input logic dr, input logic wb,
                               input int tag, input logic rdy, input logic iv, input logic bsy,
                               input logic dp, input int ld, input int exp_tag);
        vec_t r;
        r.dv = dv; r.en = en; r.dr = dr; r.wb = wb; r.tag = tag;
        r.rdy = rdy; r.iv = iv; r.bsy = bsy; r.dp = dp; r.ld = ld; r.exp_tag = exp_tag;
        return r;
    endfunction

    initial begin
        #1000000;
        $display("FAIL sim_watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[19];
        layer_desc_t q[$];
        layer_desc_t prev_out, exp_head;
        int dp_cnt, bad, exp_ld, bst, bcnt, occ;
        logic fin, exp_dp, was_iv, en_pre, acc;

        // reset values
        #7;
        chk1("rst_inst_valid", inst_valid, 1'b0);
        chk1("rst_desc_ready", desc_ready, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chkn("rst_layers_done", int'(layers_done), 0);
        chk1("rst_done_pulse", done_pulse, 1'b0);
        chk1("rst_err", err_timeout, 1'b0);
        chkd("rst_fields", out_d, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk1("rst_ready_still_low", desc_ready, 1'b0);
        step();
        chk1("rst_ready_after_edge", desc_ready, 1'b1);

        // fill to full with enable low, 5th rejected, then run the 4 layers back to back
        //         dv    en    dr    wb  tag  rdy   iv    bsy   dp   ld exp_tag
        tbl[0]  = v(1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
        tbl[1]  = v(1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
        tbl[2]  = v(1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
        tbl[3]  = v(1'b1, 1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        tbl[4]  = v(1'b1, 1'b0, 1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        tbl[5]  = v(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1);
        tbl[6]  = v(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1);
        tbl[7]  = v(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1);
        tbl[8]  = v(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1, 2);
        tbl[9]  = v(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 2);
        tbl[10] = v(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 2);
        tbl[11] = v(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 2, 3);
        tbl[12] = v(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 2, 3);
        tbl[13] = v(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 2, 3);
        tbl[14] = v(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 3, 4);
        tbl[15] = v(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 3, 4);
        tbl[16] = v(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 3, 4);
        tbl[17] = v(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 4, 4);
        tbl[18] = v(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 4, 0);
        for (int i = 0; i < 19; i++) begin
            desc_valid = tbl[i].dv; enable = tbl[i].en;
            decoder_ready = tbl[i].dr; wb_busy = tbl[i].wb;
            desc = mk_desc(tbl[i].tag);
            step();
            chk1($sformatf("T%0d_desc_ready", i), desc_ready, tbl[i].rdy);
            chk1($sformatf("T%0d_inst_valid", i), inst_valid, tbl[i].iv);
            chk1($sformatf("T%0d_busy", i), busy, tbl[i].bsy);
            chk1($sformatf("T%0d_done_pulse", i), done_pulse, tbl[i].dp);
            chkn($sformatf("T%0d_layers_done", i), int'(layers_done), tbl[i].ld);
            if (tbl[i].exp_tag != 0)
                chkd($sformatf("T%0d_fields", i), out_d, mk_desc(tbl[i].exp_tag));
        end

        // A: single layer, decoder stalls 50 cycles in issue, writeback busy 30 cycles
        dp_cnt = 0;
        decoder_ready = 1'b0; enable = 1'b1; desc_valid = 1'b1; desc = mk_desc(7);
        step(); dp_cnt += int'(done_pulse);
        desc_valid = 1'b0; desc = mk_desc(9);
        chk1("A_iv_before", inst_valid, 1'b0);
        step(); dp_cnt += int'(done_pulse);
        chk1("A_iv_rise", inst_valid, 1'b1);
        chkd("A_fields", out_d, mk_desc(7));
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step(); dp_cnt += int'(done_pulse);
            if (inst_valid !== 1'b1 || out_d !== mk_desc(7)) bad++;
        end
        chkn("A_stall_stable_bad_cycles", bad, 0);
        decoder_ready = 1'b1;
        step(); dp_cnt += int'(done_pulse);
        chk1("A_accept_first_ready", inst_valid, 1'b0);
        decoder_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin step(); dp_cnt += int'(done_pulse); end
        decoder_ready = 1'b1; wb_busy = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            step(); dp_cnt += int'(done_pulse);
            if (int'(layers_done) != 4) bad++;
        end
        chkn("A_wb_hold_bad_cycles", bad, 0);
        wb_busy = 1'b0;
        step(); dp_cnt += int'(done_pulse);
        chkn("A_layers_done", int'(layers_done), 5);
        step(); dp_cnt += int'(done_pulse);
        chkn("A_done_pulse_count", dp_cnt, 1);
        chk1("A_idle", busy, 1'b0);

        // B: abort in issue with 3 queued, concurrent push dropped
        enable = 1'b0; decoder_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            desc_valid = 1'b1; desc = mk_desc(11 + i);
            step();
        end
        desc_valid = 1'b0; enable = 1'b1;
        step();
        chk1("B_iv_issue", inst_valid, 1'b1);
        chkd("B_fields", out_d, mk_desc(11));
        abort = 1'b1; desc_valid = 1'b1; desc = mk_desc(15);
        step();
        abort = 1'b0; desc_valid = 1'b0;
        chk1("B_iv_drop", inst_valid, 1'b0);
        chk1("B_fifo_flushed", busy, 1'b0);
        chkn("B_layers_done", int'(layers_done), 5);
        step(); step(); step();
        chk1("B_no_reissue", inst_valid, 1'b0);
        chk1("B_still_idle", busy, 1'b0);

        // C: abort in WAIT_DONE completes the layer without a done pulse
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            desc_valid = 1'b1; desc = mk_desc(21 + i);
            step();
        end
        desc_valid = 1'b0; enable = 1'b1; decoder_ready = 1'b0;
        step();
        decoder_ready = 1'b1;
        step();
        decoder_ready = 1'b0;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk1("C_busy_in_wait", busy, 1'b1);
        dp_cnt = 0;
        decoder_ready = 1'b1;
        step(); dp_cnt += int'(done_pulse);
        chkn("C_layers_done", int'(layers_done), 6);
        step(); dp_cnt += int'(done_pulse);
        chkn("C_no_done_pulse", dp_cnt, 0);
        chk1("C_no_issue", inst_valid, 1'b0);
        chk1("C_idle", busy, 1'b0);

        // D: watchdog trips 100 cycles after accept; abort recovers
        decoder_ready = 1'b0; desc_valid = 1'b1; desc = mk_desc(31);
        step();
        desc_valid = 1'b0;
        step();
        decoder_ready = 1'b1;
        step();
        decoder_ready = 1'b0;
        for (int i = 0; i < 99; i++) step();
        chk1("D_err_early", err_timeout, 1'b0);
        step();
        chk1("D_err_set", err_timeout, 1'b1);
        chk1("D_iv_low", inst_valid, 1'b0);
        chk1("D_busy", busy, 1'b1);
        desc_valid = 1'b1; desc = mk_desc(32); decoder_ready = 1'b1;
        step();
        desc_valid = 1'b0;
        step(); step();
        chk1("D_no_issue_in_error", inst_valid, 1'b0);
        chk1("D_err_sticky", err_timeout, 1'b1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk1("D_err_cleared", err_timeout, 1'b0);
        chk1("D_idle", busy, 1'b0);
        chkn("D_layers_done", int'(layers_done), 6);

        // E: async reset while issuing
        decoder_ready = 1'b0; desc_valid = 1'b1; desc = mk_desc(41);
        step();
        desc_valid = 1'b0;
        step();
        chk1("E_iv_before_reset", inst_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("E_iv_async_drop", inst_valid, 1'b0);
        chk1("E_busy", busy, 1'b0);
        chkn("E_layers_done", int'(layers_done), 0);
        chk1("E_ready_low", desc_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk1("E_ready_back", desc_ready, 1'b1);

        // randomized traffic against a queue model and a decoder responder
        exp_ld = 0; bst = 0; bcnt = 0; enable = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            desc_valid = 1'($urandom_range(0, 1));
            desc = rnd_desc();
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            case (bst)
                0:       begin decoder_ready = ($urandom_range(0, 3) != 0); wb_busy = 1'b0; end
                1:       begin decoder_ready = 1'b0; wb_busy = 1'b0; end
                default: begin decoder_ready = 1'b1; wb_busy = (bcnt != 0); end
            endcase
            #1;
            occ = q.size();
            if (occ < DEPTH) chk1("R_ready_not_full", desc_ready, 1'b1);
            if (!desc_ready) chkn("R_full_when_not_ready", occ, DEPTH);
            fin = (bst == 2) && !wb_busy;
            exp_dp = fin && (occ == 0);
            was_iv = inst_valid; prev_out = out_d; en_pre = enable;
            acc = inst_valid && decoder_ready;
            if (desc_valid && desc_ready) q.push_back(desc);
            if (acc) begin
                bst = 1; bcnt = $urandom_range(1, 15);
            end else if (bst == 1) begin
                bcnt--;
                if (bcnt == 0) begin bst = 2; bcnt = $urandom_range(0, 15); end
            end else if (bst == 2) begin
                if (fin) bst = 0; else bcnt--;
            end
            if (fin) exp_ld++;
            step();
            chkn("R_layers_done", int'(layers_done), exp_ld);
            chk1("R_done_pulse", done_pulse, exp_dp);
            if (bst != 0) chk1("R_iv_low_while_running", inst_valid, 1'b0);
            if (inst_valid && !was_iv) begin
                chk1("R_issue_needs_enable", en_pre, 1'b1);
                chkn("R_issue_has_entry", (q.size() > 0) ? 1 : 0, 1);
                if (q.size() > 0) begin
                    exp_head = q.pop_front();
                    chkd("R_issue_fields", out_d, exp_head);
                end
            end else if (inst_valid) begin
                chkd("R_fields_stable", out_d, prev_out);
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
